// File: rtl/mac_seq_if.sv
// Bus between mac_seq, its activation/weight read ports and the downstream MAC stage.
// master = sequencer side, slave = memories/MAC/host side.
interface mac_seq_if #(
  parameter int WADDR_W = 14
);
  logic                      go;
  logic                      busy;
  logic                      done;
  logic                      in_rd_en;
  logic        [6:0]         in_rd_addr;
  logic signed [15:0]        in_rd_data;
  logic                      w_rd_en;
  logic        [WADDR_W-1:0] w_rd_addr;
  logic signed [15:0]        w_rd_data;
  logic signed [15:0]        mac_in;
  logic signed [15:0]        weight;
  logic        [6:0]         addr_in;
  logic                      start;

  modport master (
    input  go, in_rd_data, w_rd_data,
    output busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
           mac_in, weight, addr_in, start
  );

  modport slave (
    output go, in_rd_data, w_rd_data,
    input  busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
           mac_in, weight, addr_in, start
  );
endinterface

// File: rtl/mac_seq.sv
// Operand/address sequencer feeding a 6-deep read-modify-write MAC pipeline.
// Define MAC_SEQ_BIAS_EN to add a bias pass (mac_in = ONE_VAL) after the last input row.
//
// state | meaning
// IDLE  | waiting for go
// ISSUE | one activation + weight read per cycle, j inner, i outer
// GAP   | bubble cycles so a psum address is not reused within PIPE_DEPTH
// BIAS  | (MAC_SEQ_BIAS_EN) weight-only pass over the bias region
// DRAIN | PIPE_DEPTH+1 bubble cycles while the MAC empties
// DONE  | one-cycle done pulse, busy low
module mac_seq #(
  parameter int                 NUM_IN      = 100,
  parameter int                 NUM_OUT     = 100,
  parameter int                 PIPE_DEPTH  = 6,
  parameter int                 BUBBLE_ADDR = 127,
  parameter int                 WADDR_W     = 14,
  parameter logic signed [15:0] ONE_VAL     = 16'sd1
) (
  input  logic      clk,
  input  logic      reset,
  mac_seq_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef MAC_SEQ_BIAS_EN
  localparam logic [2:0] S_BIAS  = 3'd5;
`endif

  localparam bit         NEED_GAP   = NUM_OUT < PIPE_DEPTH;
  // Only meaningful when NEED_GAP; timers count down to zero inclusive.
  localparam logic [7:0] GAP_LOAD   = 8'(PIPE_DEPTH - NUM_OUT - 1);
  localparam logic [7:0] DRAIN_LOAD = 8'(PIPE_DEPTH);

  logic [2:0]         state_q, state_d;
  logic [6:0]         i_q, i_d;
  logic [6:0]         j_q, j_d;
  logic [WADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]         tmr_q, tmr_d;
`ifdef MAC_SEQ_BIAS_EN
  logic               bias_q, bias_d;
`endif

  logic       vld_q;
  logic [6:0] jd_q;
  logic       start_q;
  logic       one_q;

  logic       rd_w, rd_in, bias_issue;
  logic       j_last, row_last, row_end;
  logic [2:0] after_row;

  assign rd_in    = state_q == S_ISSUE;
  assign j_last   = j_q == 7'(NUM_OUT - 1);
  assign row_last = i_q == 7'(NUM_IN - 1);

`ifdef MAC_SEQ_BIAS_EN
  assign bias_issue = state_q == S_BIAS;
`else
  assign bias_issue = 1'b0;
`endif
  assign rd_w = rd_in | bias_issue;

  // Where a completed row (including its gap) leads.
  always_comb begin
    after_row = S_ISSUE;
`ifdef MAC_SEQ_BIAS_EN
    if (bias_q)        after_row = S_DRAIN;
    else if (row_last) after_row = S_BIAS;
`else
    if (row_last)      after_row = S_DRAIN;
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
`ifdef MAC_SEQ_BIAS_EN
    bias_d  = bias_q;
`endif
    row_end = 1'b0;

    if (rd_w) begin
      cnt_d = cnt_q + WADDR_W'(1);
      if (j_last) begin
        j_d = '0;
        if (NEED_GAP) begin
          state_d = S_GAP;
          tmr_d   = GAP_LOAD;
        end else begin
          row_end = 1'b1;
        end
      end else begin
        j_d = j_q + 7'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
`ifdef MAC_SEQ_BIAS_EN
          bias_d  = 1'b0;
`endif
        end
      end
      S_GAP: begin
        if (tmr_q == '0) row_end = 1'b1;
        else             tmr_d   = tmr_q - 8'd1;
      end
      S_DRAIN: begin
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: if (!rd_w) state_d = S_IDLE;
    endcase

    if (row_end) begin
      state_d = after_row;
      if (after_row == S_ISSUE) i_d   = i_q + 7'd1;
      if (after_row == S_DRAIN) tmr_d = DRAIN_LOAD;
`ifdef MAC_SEQ_BIAS_EN
      if (after_row == S_BIAS)  bias_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
`ifdef MAC_SEQ_BIAS_EN
      bias_q  <= 1'b0;
`endif
      vld_q   <= 1'b0;
      jd_q    <= '0;
      start_q <= 1'b0;
      one_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
`ifdef MAC_SEQ_BIAS_EN
      bias_q  <= bias_d;
`endif
      // Operand alignment: the memories answer one cycle after the read.
      vld_q   <= rd_w;
      jd_q    <= j_q;
      start_q <= rd_in && (i_q == '0) && (j_q == '0);
      one_q   <= bias_issue;
    end
  end

  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = state_q == S_DONE;
  assign bus.in_rd_en   = rd_in;
  assign bus.in_rd_addr = i_q;
  assign bus.w_rd_en    = rd_w;
  assign bus.w_rd_addr  = cnt_q;
  assign bus.addr_in    = vld_q ? jd_q : 7'(BUBBLE_ADDR);
  assign bus.start      = start_q;
  assign bus.weight     = vld_q ? bus.w_rd_data : '0;
  assign bus.mac_in     = !vld_q ? '0 : (one_q ? ONE_VAL : bus.in_rd_data);

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: randomized memory contents, expected issue/operand
// streams and psums built from the layer-walk rules in a queue-based reference model.
module tb_mac_seq;
  localparam int PD  = 6;
  localparam int BUB = 127;
`ifdef MAC_SEQ_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  typedef struct {
    bit ien;
    bit wen;
    int i;
    int w;
    int j;
    bit b;
  } slot_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic go    = 1'b0;
  int   sel   = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  logic signed [15:0] in_mem [128];
  logic signed [15:0] w_mem  [16384];

  always #5 clk = ~clk;

  mac_seq_if #(.WADDR_W(14)) ifa ();
  mac_seq_if #(.WADDR_W(14)) ifb ();
  mac_seq #(.NUM_IN(2), .NUM_OUT(3)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  mac_seq dut_b (.clk(clk), .reset(reset), .bus(ifb.master));
  assign ifa.go = go && (sel == 0);
  assign ifb.go = go && (sel == 1);

  always @(posedge clk) begin
    if (ifa.in_rd_en) ifa.in_rd_data <= in_mem[ifa.in_rd_addr];
    if (ifa.w_rd_en)  ifa.w_rd_data  <= w_mem[ifa.w_rd_addr];
    if (ifb.in_rd_en) ifb.in_rd_data <= in_mem[ifb.in_rd_addr];
    if (ifb.w_rd_en)  ifb.w_rd_data  <= w_mem[ifb.w_rd_addr];
  end

`ifdef MAC_SEQ_BIAS_EN
  mac_seq_if #(.WADDR_W(14)) ifc ();
  mac_seq #(.NUM_IN(1), .NUM_OUT(8)) dut_c (.clk(clk), .reset(reset), .bus(ifc.master));
  assign ifc.go = go && (sel == 2);
  always @(posedge clk) begin
    if (ifc.in_rd_en) ifc.in_rd_data <= in_mem[ifc.in_rd_addr];
    if (ifc.w_rd_en)  ifc.w_rd_data  <= w_mem[ifc.w_rd_addr];
  end
`endif

  logic               o_busy, o_done, o_ien, o_wen, o_start;
  logic        [6:0]  o_iaddr, o_addr;
  logic        [13:0] o_waddr;
  logic signed [15:0] o_mac, o_w;

  always_comb begin
    o_busy = ifa.busy;  o_done = ifa.done;  o_ien = ifa.in_rd_en;  o_wen = ifa.w_rd_en;
    o_start = ifa.start; o_iaddr = ifa.in_rd_addr; o_addr = ifa.addr_in;
    o_waddr = ifa.w_rd_addr; o_mac = ifa.mac_in; o_w = ifa.weight;
    if (sel == 1) begin
      o_busy = ifb.busy;  o_done = ifb.done;  o_ien = ifb.in_rd_en;  o_wen = ifb.w_rd_en;
      o_start = ifb.start; o_iaddr = ifb.in_rd_addr; o_addr = ifb.addr_in;
      o_waddr = ifb.w_rd_addr; o_mac = ifb.mac_in; o_w = ifb.weight;
    end
`ifdef MAC_SEQ_BIAS_EN
    if (sel == 2) begin
      o_busy = ifc.busy;  o_done = ifc.done;  o_ien = ifc.in_rd_en;  o_wen = ifc.w_rd_en;
      o_start = ifc.start; o_iaddr = ifc.in_rd_addr; o_addr = ifc.addr_in;
      o_waddr = ifc.w_rd_addr; o_mac = ifc.mac_in; o_w = ifc.weight;
    end
`endif
  end

  task automatic chk(input string name, input longint got, input longint exp, input string note);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d %s", name, got, exp, note);
    end
  endtask

  task automatic rand_mem(input int n_in, input int n_w);
    for (int k = 0; k < n_in; k++) in_mem[k] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < n_w; k++)  w_mem[k]  = 16'($urandom_range(0, 65535));
  endtask

  // Run one job on the selected DUT and compare every cycle against the model stream.
  // go_at >= 0 pulses go in that job cycle; rst_at >= 0 aborts the job with reset there.
  task automatic run_job(input int ni, input int no, input int go_at, input int rst_at,
                         input bit go_in_done, input string tag);
    slot_t  q[$];
    slot_t  s, p, idle;
    int     wa = 0;
    int     nq, done_c, n_done, bad_rd, bad_out, bad_ctl, ps_bad, min_dist;
    string  f_rd, f_out, f_ctl, f_ps;
    int     last_seen [128];
    longint ps_obs [128];
    longint e_ps, e_ps0;
    int     e_addr, e_mac, e_w;
    bit     e_start;

    idle = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < ni; i++) begin
      for (int j = 0; j < no; j++) begin
        q.push_back('{1, 1, i, wa, j, 0});
        wa++;
      end
      for (int g = no; g < PD; g++) q.push_back(idle);
    end
    if (BIAS) begin
      for (int j = 0; j < no; j++) begin
        q.push_back('{0, 1, 0, wa, j, 1});
        wa++;
      end
      for (int g = no; g < PD; g++) q.push_back(idle);
    end
    for (int k = 0; k <= PD; k++) q.push_back(idle);
    nq = q.size();

    done_c = -1; n_done = 0; bad_rd = 0; bad_out = 0; bad_ctl = 0; ps_bad = 0;
    min_dist = 1 << 30;
    f_rd = ""; f_out = ""; f_ctl = ""; f_ps = "";
    for (int k = 0; k < 128; k++) begin
      last_seen[k] = -1;
      ps_obs[k]    = 0;
    end

    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int c = 0; c <= nq; c++) begin
      s = (c < nq) ? q[c] : idle;
      p = (c >= 1) ? q[c-1] : idle;
      if (o_ien !== s.ien || o_wen !== s.wen || (s.ien && o_iaddr !== 7'(s.i)) ||
          (s.wen && o_waddr !== 14'(s.w))) begin
        if (bad_rd == 0)
          f_rd = $sformatf("(cycle %0d en=%b%b/%b%b iaddr=%0d/%0d waddr=%0d/%0d)", c, o_ien, o_wen,
                           s.ien, s.wen, o_iaddr, s.i, o_waddr, s.w);
        bad_rd++;
      end
      e_addr = p.wen ? p.j : BUB;
      e_mac  = !p.wen ? 0 : (p.b ? 1 : int'(in_mem[p.i]));
      e_w    = p.wen ? int'(w_mem[p.w]) : 0;
      if (int'(o_addr) !== e_addr || int'(o_mac) !== e_mac || int'(o_w) !== e_w) begin
        if (bad_out == 0)
          f_out = $sformatf("(cycle %0d addr=%0d/%0d mac=%0d/%0d w=%0d/%0d)", c, o_addr, e_addr,
                            o_mac, e_mac, o_w, e_w);
        bad_out++;
      end
      e_start = (c == 1);
      if (o_busy !== (c < nq) || o_done !== (c == nq) || o_start !== e_start) begin
        if (bad_ctl == 0)
          f_ctl = $sformatf("(cycle %0d busy=%b done=%b start=%b)", c, o_busy, o_done, o_start);
        bad_ctl++;
      end
      if (o_done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (o_addr != 7'(BUB)) begin
        if (last_seen[o_addr] >= 0 && c - last_seen[o_addr] < min_dist)
          min_dist = c - last_seen[o_addr];
        last_seen[o_addr] = c;
        ps_obs[o_addr] += longint'(o_mac) * longint'(o_w);
      end
      go = (c == go_at) || (go_in_done && c == nq);
      if (c == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        go    = 1'b0;
        chk({tag, ".rst_outs"}, {o_busy, o_done, o_ien, o_wen, o_start, o_addr, o_mac, o_w},
            {5'b0, 7'(BUB), 32'd0}, "");
        chk({tag, ".rst_addrs"}, {o_iaddr, o_waddr}, 21'd0, "");
        return;
      end
      @(negedge clk);
    end
    go = 1'b0;

    chk({tag, ".rd_seq"},    bad_rd,  0, f_rd);
    chk({tag, ".out_seq"},   bad_out, 0, f_out);
    chk({tag, ".ctl_seq"},   bad_ctl, 0, f_ctl);
    chk({tag, ".done_cyc"},  done_c,  nq, "");
    chk({tag, ".done_cnt"},  n_done,  1, "");
    chk({tag, ".reuse_ok"},  (min_dist >= PD) ? 1 : 0, 1, $sformatf("(min distance %0d)", min_dist));
    chk({tag, ".idle_after"}, {o_busy, o_done, o_wen, o_ien}, 4'd0, "");

    e_ps0 = 0;
    for (int j = 0; j < no; j++) begin
      e_ps = 0;
      for (int i = 0; i < ni; i++) e_ps += longint'(in_mem[i]) * longint'(w_mem[i*no + j]);
      if (BIAS) e_ps += longint'(w_mem[ni*no + j]);
      if (j == 0) e_ps0 = e_ps;
      if (ps_obs[j] !== e_ps) begin
        if (ps_bad == 0) f_ps = $sformatf("(psum[%0d]=%0d/%0d)", j, ps_obs[j], e_ps);
        ps_bad++;
      end
    end
    chk({tag, ".psum0"},    ps_obs[0], e_ps0, "");
    chk({tag, ".psum_all"}, ps_bad,    0, f_ps);
  endtask

  initial begin
    for (int k = 0; k < 128; k++)   in_mem[k] = '0;
    for (int k = 0; k < 16384; k++) w_mem[k]  = '0;
    repeat (3) @(negedge clk);
    chk("reset.addrs", {o_iaddr, o_waddr}, 21'd0, "");
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle", {o_busy, o_done, o_ien, o_wen, o_start, o_addr, o_mac, o_w},
          {5'b0, 7'(BUB), 32'd0}, $sformatf("(idle cycle %0d)", k));
    end

    sel = 0;
    rand_mem(2, 12);
    run_job(2, 3, -1, -1, 1'b0, "a0");
    rand_mem(2, 12);
    run_job(2, 3, 4, -1, 1'b1, "a1");

    sel = 1;
    for (int k = 0; k < 100; k++)   in_mem[k] = 16'(k);
    for (int k = 0; k < 10100; k++) w_mem[k]  = 16'sd1;
    run_job(100, 100, 50, -1, 1'b0, "b_plan");
    rand_mem(100, 10100);
    run_job(100, 100, -1, 30, 1'b0, "b_abort");
    run_job(100, 100, -1, -1, 1'b0, "b_fresh");

`ifdef MAC_SEQ_BIAS_EN
    sel = 2;
    rand_mem(1, 8);
    for (int j = 0; j < 8; j++) w_mem[8 + j] = 16'(j);
    run_job(1, 8, -1, -1, 1'b0, "c_bias");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Operand/address sequencer that sits directly upstream of the pipelined MAC stage.
- Walks one layer (NUM_IN inputs × NUM_OUT outputs), fetches input activations and weights from external 1-cycle-latency memories, and drives the MAC's mac_in/weight/addr_in/start.
- Orders issue so that no psum address re-enters the MAC's 6-deep read-modify-write pipeline while a prior update to it is in flight.
- Drains the pipeline and signals done.

Parameters:
NUM_IN, 100, input activations per job (1..127)
NUM_OUT, 100, output neurons / psum addresses (1..100)
PIPE_DEPTH, 6, MAC cycles from addr_in to psum writeback
BUBBLE_ADDR, 127, addr_in value the MAC treats as invalid (>99)
WADDR_W, 14, weight memory address width
ONE_VAL, 16'sd1, activation value used for the bias pass (optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
go  in  1  start a job; sampled only in IDLE
busy  out  1  high from go acceptance until done
done  out  1  one-cycle pulse at job completion
in_rd_en  out  1  input memory read enable
in_rd_addr  out  7  input activation index i
in_rd_data  in  16  signed activation, valid cycle after in_rd_en
w_rd_en  out  1  weight memory read enable
w_rd_addr  out  WADDR_W  weight index i*NUM_OUT+j
w_rd_data  in  16  signed weight, valid cycle after w_rd_en
mac_in  out  16  signed operand to MAC
weight  out  16  signed weight to MAC
addr_in  out  7  psum address j, or BUBBLE_ADDR
start  out  1  high with the first valid operand of a job

Behaviour:
- Reset: state IDLE; busy=0, done=0, in_rd_en=0, w_rd_en=0, in_rd_addr=0, w_rd_addr=0, addr_in=BUBBLE_ADDR, start=0, mac_in=0, weight=0. Reset mid-job aborts immediately; no further valid addr_in is issued.
- States: IDLE, ISSUE, GAP, DRAIN, DONE.
- IDLE: go=1 → ISSUE; i=0, j=0, weight counter=0, busy=1.
- ISSUE:
  - Each cycle assert in_rd_en/w_rd_en with in_rd_addr=i, w_rd_addr=counter, then counter+1.
  - Inner loop is j=0..NUM_OUT-1; outer loop is i.
  - At j wrap: if NUM_OUT<PIPE_DEPTH → GAP; else i+1.
  - After i=NUM_IN-1, j=NUM_OUT-1 → DRAIN.
- GAP: exactly PIPE_DEPTH-NUM_OUT bubble cycles with no reads. Then i+1 and return to ISSUE, or go to DRAIN if that was the last i. This guarantees a same-address reuse distance ≥ PIPE_DEPTH.
- Alignment (1-cycle latency):
  - A read issued in cycle c produces the following in cycle c+1: mac_in=in_rd_data, weight=w_rd_data, addr_in=j registered from cycle c, start=1 only for the (i=0, j=0) issue.
  - Any cycle with no read in cycle c-1 drives addr_in=BUBBLE_ADDR, mac_in=0, weight=0, start=0.
- DRAIN: PIPE_DEPTH+1 cycles of bubbles, then DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Timing: with T = NUM_IN*max(NUM_OUT,PIPE_DEPTH), first issue cycle = 0 (cycle after go sampled), done is high in cycle T+PIPE_DEPTH+1.
- go while busy: ignored. go in the DONE cycle: ignored. go held high through IDLE: starts a new job back-to-back.
- Psum clearing is not this block's job; the register file is zeroed before go.
- w_rd_addr does not wrap within a job; max value NUM_IN*NUM_OUT-1 (plus the bias region if enabled).

Optional Feature:
- MAC_SEQ_BIAS_EN defined:
  - After the last i (before DRAIN), run one extra NUM_OUT-cycle pass (state BIAS, GAP rules apply).
  - w_rd_addr continues at NUM_IN*NUM_OUT + j; in_rd_en=0; mac_in is forced to ONE_VAL, so each psum receives + bias[j].
  - T grows by max(NUM_OUT,PIPE_DEPTH).
- Undefined: no BIAS state; the weight region ends at NUM_IN*NUM_OUT-1.

Test Plan:
- Reset, then idle 10 cycles → addr_in=127, start=0, busy=0, done=0, no rd_en.
- NUM_IN=2, NUM_OUT=3 (PIPE_DEPTH=6) → addr_in sequence 0,1,2,127,127,127,0,1,2; w_rd_addr 0..5; start only with first addr 0; done at cycle 12+7=19.
- Default 100×100, weights=1, inputs=i → every psum receives sum(0..99)=4950; done at cycle 10007; busy deasserts with done.
- go pulsed during ISSUE at cycle 50 → ignored; w_rd_addr stays monotonic, single done.
- reset asserted at cycle 30 of a job → next cycle all outputs at reset values; a fresh go restarts from i=0, j=0.
- MAC_SEQ_BIAS_EN, NUM_IN=1, NUM_OUT=8, bias[j]=j → mac_in=1 and w_rd_addr 8..15 on the bias pass; psum[j] = x0*w[j] + j.
